pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_stage_reg_if.sv | 30 +++
 rtl/pipe_stage_reg_sat_counter.sv | 20 ++
 rtl/pipe_stage_reg.sv | 106 ++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and control-field layout for pipeline stage registers.
package pipe_pkg;

  localparam int unsigned DATA_W_DEF = 160;
  localparam int unsigned CTRL_W_DEF = 10;
  localparam int unsigned CNT_W_DEF  = 16;

  // Bit positions of the control fields carried in ctrl.
  localparam int unsigned CTRL_ALUOP_LSB = 0;
  localparam int unsigned CTRL_ALUOP_W   = 4;
  localparam int unsigned CTRL_MEMWRITE  = 4;
  localparam int unsigned CTRL_REGWRITE  = 5;
  localparam int unsigned CTRL_MEMTOREG  = 6;
  localparam int unsigned CTRL_SEL_LSB   = 7;
  localparam int unsigned CTRL_SEL_W     = 3;

  // Storage movement chosen for the coming clock edge.
  typedef enum logic [2:0] {
    MOVE_IDLE,
    MOVE_LOAD_MAIN,
    MOVE_LOAD_SKID,
    MOVE_SKID_TO_MAIN,
    MOVE_DRAIN,
    MOVE_FLUSH
  } move_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of a pipeline stage register.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  // Environment side: feeds the stage and consumes its output.
  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  // Stage side.
  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );

endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stage statistics.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with flush and statistics.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic  accept;
  logic  take;
  move_e move;

  assign bus.in_ready  = !skid_valid && !flush;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_ctrl  = main_ctrl;

  assign accept = bus.in_valid && bus.in_ready;
  assign take   = main_valid && bus.out_ready;

  // Select the storage movement for the next edge; flush overrides all moves.
  always_comb begin
    move = MOVE_IDLE;
    if (flush) begin
      move = MOVE_FLUSH;
    end else if (take && skid_valid) begin
      move = MOVE_SKID_TO_MAIN;
    end else if (accept && (!main_valid || take)) begin
      move = MOVE_LOAD_MAIN;
    end else if (accept) begin
      move = MOVE_LOAD_SKID;
    end else if (take) begin
      move = MOVE_DRAIN;
    end
  end

  // Apply the selected movement; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else begin
      case (move)
        MOVE_FLUSH: begin
          // Payload is kept so out_data does not glitch; only ctrl is cleared.
          main_valid <= 1'b0;
          main_ctrl  <= '0;
          skid_valid <= 1'b0;
        end
        MOVE_SKID_TO_MAIN: begin
          main_data  <= skid_data;
          main_ctrl  <= skid_ctrl;
          skid_valid <= 1'b0;
        end
        MOVE_LOAD_MAIN: begin
          main_valid <= 1'b1;
          main_data  <= bus.in_data;
          main_ctrl  <= bus.in_ctrl;
        end
        MOVE_LOAD_SKID: begin
          skid_valid <= 1'b1;
          skid_data  <= bus.in_data;
          skid_ctrl  <= bus.in_ctrl;
        end
        MOVE_DRAIN: begin
          main_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (main_valid && !bus.out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!main_valid),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [15:0] stall_cnt, bubble_cnt;
  logic [2:0]  stall2, bubble2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(160), .CTRL_W(10)) bus ();
  pipe_stage_reg_if #(.DATA_W(160), .CTRL_W(10)) bus2 ();

  pipe_stage_reg #(.DATA_W(160), .CTRL_W(10), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_reg #(.DATA_W(160), .CTRL_W(10), .CNT_W(3)) dut_small (
    .clk        (clk),
    .reset      (reset),
    .flush      (1'b0),
    .bus        (bus2),
    .stall_cnt  (stall2),
    .bubble_cnt (bubble2)
  );

  typedef struct {
    logic         fl;
    logic         iv;
    logic [159:0] d;
    logic [9:0]   c;
    logic         ordy;
    logic         ev;
    logic [159:0] ed;
    logic [9:0]   ec;
    logic         eir;
    logic [15:0]  es;
    logic [15:0]  eb;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic fl, logic iv, logic [159:0] d, logic [9:0] c,
                              logic ordy, logic ev, logic [159:0] ed, logic [9:0] ec,
                              logic eir, logic [15:0] es, logic [15:0] eb);
    vec_t r;
    r.fl = fl; r.iv = iv; r.d = d; r.c = c; r.ordy = ordy;
    r.ev = ev; r.ed = ed; r.ec = ec; r.eir = eir; r.es = es; r.eb = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [159:0] d,
                       input logic [9:0] c, input logic ordy);
    flush        = fl;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    bus.out_ready = ordy;
  endtask

  initial begin
    // Rows: inputs applied for one edge, then expected state after that edge.
    //           fl iv data     ctrl      ordy ev exp_data exp_ctrl  ir stall bubble
    vt[0]  = mk(0, 1, 160'h1,  10'h011, 1,  1, 160'h1,  10'h011, 1, 0, 1);
    vt[1]  = mk(0, 0, 160'h0,  10'h000, 0,  1, 160'h1,  10'h011, 1, 1, 1);
    vt[2]  = mk(0, 0, 160'h0,  10'h000, 1,  0, 160'h1,  10'h011, 1, 1, 1);
    vt[3]  = mk(0, 1, 160'h10, 10'h0A1, 0,  1, 160'h10, 10'h0A1, 1, 1, 2);
    vt[4]  = mk(0, 1, 160'h20, 10'h0B2, 0,  1, 160'h10, 10'h0A1, 0, 2, 2);
    vt[5]  = mk(0, 1, 160'h30, 10'h0C3, 0,  1, 160'h10, 10'h0A1, 0, 3, 2);
    vt[6]  = mk(0, 1, 160'h30, 10'h0C3, 1,  1, 160'h20, 10'h0B2, 1, 3, 2);
    vt[7]  = mk(0, 1, 160'h30, 10'h0C3, 1,  1, 160'h30, 10'h0C3, 1, 3, 2);
    vt[8]  = mk(0, 0, 160'h0,  10'h000, 1,  0, 160'h30, 10'h0C3, 1, 3, 2);
    vt[9]  = mk(0, 1, 160'h40, 10'h1D4, 0,  1, 160'h40, 10'h1D4, 1, 3, 3);
    vt[10] = mk(0, 1, 160'h50, 10'h1E5, 0,  1, 160'h40, 10'h1D4, 0, 4, 3);
    vt[11] = mk(1, 1, 160'h60, 10'h2F6, 0,  0, 160'h40, 10'h000, 0, 5, 3);
    vt[12] = mk(0, 0, 160'h0,  10'h000, 1,  0, 160'h40, 10'h000, 1, 5, 4);
    vt[13] = mk(0, 1, 160'h70, 10'h3C7, 1,  1, 160'h70, 10'h3C7, 1, 5, 5);
    vt[14] = mk(1, 0, 160'h0,  10'h000, 1,  0, 160'h70, 10'h000, 0, 5, 5);
    vt[15] = mk(0, 0, 160'h0,  10'h000, 1,  0, 160'h70, 10'h000, 1, 5, 6);

    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.in_ctrl   = '0;
    bus2.out_ready = 1'b0;
    reset = 1'b1;
    drive(0, 0, 160'h0, 10'h0, 0);
    step();
    step();

    chk("reset out_valid",  bus.out_valid, 0);
    chk("reset out_data",   bus.out_data, 0);
    chk("reset out_ctrl",   bus.out_ctrl, 0);
    chk("reset stall_cnt",  stall_cnt, 0);
    chk("reset bubble_cnt", bubble_cnt, 0);
    chk("reset in_ready",   bus.in_ready, 1);
    chk("reset small bubble", bubble2, 0);

    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(vt[i].fl, vt[i].iv, vt[i].d, vt[i].c, vt[i].ordy);
      step();
      chk($sformatf("row%0d out_valid", i),  bus.out_valid, vt[i].ev);
      chk($sformatf("row%0d out_data", i),   bus.out_data, vt[i].ed);
      chk($sformatf("row%0d out_ctrl", i),   bus.out_ctrl, vt[i].ec);
      chk($sformatf("row%0d in_ready", i),   bus.in_ready, vt[i].eir);
      chk($sformatf("row%0d stall_cnt", i),  stall_cnt, vt[i].es);
      chk($sformatf("row%0d bubble_cnt", i), bubble_cnt, vt[i].eb);
      chk($sformatf("row%0d small bubble", i), bubble2, (i + 1 > 7) ? 7 : i + 1);
      chk($sformatf("row%0d small stall", i), stall2, 0);
    end

    // Five stalled edges with a full stage, then drain A, B, C back to back.
    reset = 1'b1;
    drive(0, 0, 160'h0, 10'h0, 0);
    step();
    reset = 1'b0;
    drive(0, 1, 160'h10, 10'h0A1, 0);
    step();
    chk("stall A loaded", bus.out_data, 160'h10);
    drive(0, 1, 160'h20, 10'h0B2, 0);
    step();
    chk("stall skid full in_ready", bus.in_ready, 0);
    drive(0, 1, 160'h30, 10'h0C3, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall hold%0d out_data", k), bus.out_data, 160'h10);
      chk($sformatf("stall hold%0d out_valid", k), bus.out_valid, 1);
      chk($sformatf("stall hold%0d in_ready", k), bus.in_ready, 0);
    end
    chk("stall count five", stall_cnt, 5);
    bus.out_ready = 1'b1;
    step();
    chk("drain B data",  bus.out_data, 160'h20);
    chk("drain B valid", bus.out_valid, 1);
    step();
    chk("drain C data",  bus.out_data, 160'h30);
    chk("drain C ctrl",  bus.out_ctrl, 10'h0C3);
    chk("drain C valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    step();
    chk("drain empty valid", bus.out_valid, 0);
    chk("drain stall held",  stall_cnt, 5);

    // Reset together with flush while both entries are full.
    drive(0, 1, 160'h80, 10'h2A8, 0);
    step();
    drive(0, 1, 160'h90, 10'h2B9, 0);
    step();
    chk("rstflush skid full", bus.in_ready, 0);
    reset = 1'b1;
    drive(1, 1, 160'hA0, 10'h2CA, 0);
    step();
    chk("rstflush out_valid",  bus.out_valid, 0);
    chk("rstflush out_data",   bus.out_data, 0);
    chk("rstflush out_ctrl",   bus.out_ctrl, 0);
    chk("rstflush stall_cnt",  stall_cnt, 0);
    chk("rstflush bubble_cnt", bubble_cnt, 0);
    reset = 1'b0;
    drive(0, 0, 160'h0, 10'h0, 0);
    #1;
    chk("post reset in_ready", bus.in_ready, 1);
    step();
    chk("post reset out_valid",  bus.out_valid, 0);
    chk("post reset bubble_cnt", bubble_cnt, 1);
    chk("post reset stall_cnt",  stall_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
